// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: memory-stage load/store unit.
//
// Accepts one load or store per transaction using the ALU result as the
// effective address. It drives a req/gnt/rvalid data-memory bus and returns
// sign- or zero-extended load data with a one-cycle done pulse. While a
// transaction is on the bus it holds busy high so the pipeline stalls.
//
// Ports
//   clk, rst         single clock; synchronous active-high reset
//   req_valid        memory op present in the stage
//   mem_read         load op
//   mem_write        store op
//   funct3           size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata      effective address and store data (rs2)
//   busy             combinational stall request
//   done             one-cycle completion pulse
//   err, err_code    valid with done: 01 misaligned, 10 bus timeout,
//                    11 illegal funct3 / both read and write
//   load_data        extended load result, valid while done=1
//   dmem_*           data-memory bus (word address, byte enables,
//                    lane-replicated write data, gnt/rvalid/rdata)
module lsu_dmem_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [1:0]       ERR_MISAL = 2'b01;
    localparam logic [1:0]       ERR_TMO   = 2'b10;
    localparam logic [1:0]       ERR_ILL   = 2'b11;
    // Last counter value still allowed in REQ/WAIT; a completion on this
    // cycle still succeeds, otherwise the transaction is aborted.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_load;
    logic [2:0]       size_q;
    logic [1:0]       off_q;

    logic             f3_legal;
    logic             misal;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;
    logic [15:0]      sh16;
    logic [31:0]      ext;

    // Decode of the incoming op, used only at accept.
    always_comb begin
        f3_legal   = 1'b0;
        misal      = 1'b0;
        be_next    = 4'b0000;
        wdata_next = 32'h0;
        case (funct3)
            3'b000, 3'b100: begin
                f3_legal   = 1'b1;
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                f3_legal   = 1'b1;
                misal      = addr[0];
                be_next    = 4'b0011 << addr[1:0];
                wdata_next = {2{wdata[15:0]}};
            end
            3'b010: begin
                f3_legal   = 1'b1;
                misal      = |addr[1:0];
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend by size.
    always_comb begin
        sh16 = 16'(dmem_rdata >> {off_q, 3'b000});
        case (size_q)
            3'b000:  ext = {{24{sh16[7]}}, sh16[7:0]};
            3'b100:  ext = {24'h0, sh16[7:0]};
            3'b001:  ext = {{16{sh16[15]}}, sh16};
            3'b101:  ext = {16'h0, sh16};
            default: ext = dmem_rdata;
        endcase
    end

    // Stall in IDLE as soon as an op shows up so the stage holds its operands
    // through the accept edge; released in DONE so the result advances.
    assign busy = (state == REQ) || (state == WAIT) ||
                  ((state == IDLE) && req_valid && (mem_read || mem_write));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            load_data  <= 32'h0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0;
            is_load    <= 1'b0;
            size_q     <= 3'b000;
            off_q      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && (mem_read || mem_write)) begin
                        cnt     <= '0;
                        is_load <= mem_read;
                        size_q  <= funct3;
                        off_q   <= addr[1:0];
                        if ((mem_read && mem_write) || !f3_legal) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            err_code  <= ERR_ILL;
                            load_data <= 32'h0;
                        end else if (misal) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            err_code  <= ERR_MISAL;
                            load_data <= 32'h0;
                        end else begin
                            state      <= REQ;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {addr[31:2], 2'b00};
                            dmem_be    <= be_next;
                            dmem_wdata <= wdata_next;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (dmem_gnt && (!is_load || dmem_rvalid)) begin
                        // Store, or load with data in the grant cycle.
                        state     <= DONE;
                        dmem_req  <= 1'b0;
                        done      <= 1'b1;
                        load_data <= is_load ? ext : 32'h0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        dmem_req  <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        err_code  <= ERR_TMO;
                        load_data <= 32'h0;
                    end else if (dmem_gnt) begin
                        state    <= WAIT;
                        dmem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (dmem_rvalid) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        load_data <= ext;
                    end else if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        err_code  <= ERR_TMO;
                        load_data <= 32'h0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    err_code <= 2'b00;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: directed table, hand sequences for reset and
// ignored requests, then randomized ops checked against a transaction-level
// model (latency, error class, byte lanes, extension).
module tb_lsu_dmem_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] load_data;
    logic [1:0]  err_code;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_dmem_ctrl #(.TIMEOUT(TO), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .load_data(load_data),
        .err(err), .err_code(err_code),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    // gw: REQ cycles before gnt (0 = first REQ cycle; >= TO means never).
    // rv: cycles from gnt to rvalid (0 = same cycle).
    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, wd, rdata;
        int          gw, rv;
    } vec_t;

    typedef struct {
        int          done_cyc;
        logic        err;
        logic [1:0]  code;
        logic [31:0] ld;
        int          nreq;
        logic [31:0] addr, wd;
        logic [3:0]  be;
        logic        we;
    } exp_t;

    typedef struct {
        int          done_cyc;
        logic        err;
        logic [1:0]  code;
        logic [31:0] ld, addr, wd, ld_after;
        logic [3:0]  be;
        logic        we, stable, busy_t, busy_mid, busy_done, done_after;
        int          nreq;
    } obs_t;

    typedef struct {
        vec_t        v;
        int          done_cyc;
        logic        err;
        logic [1:0]  code;
        logic [31:0] ld;
        logic [3:0]  be;
    } tv_t;

    tv_t tv[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: what the op should produce, from the
    // size/alignment rules and the bus response timing.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        int unsigned off, lane, c;
        off = v.a % 4;
        e = '{done_cyc: 1, err: 1'b0, code: 2'b00, ld: 32'h0, nreq: 0,
              addr: v.a - off, wd: v.wd, be: 4'hF, we: v.wr};
        case (v.f3 % 4)
            0: begin e.be = 4'(1 << off); e.wd = (v.wd % 256) * 32'h01010101; end
            1: begin e.be = 4'(3 << off); e.wd = (v.wd % 65536) * 32'h00010001; end
            default: ;
        endcase
        if ((v.rd && v.wr) || !(v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
            e.err = 1'b1; e.code = 2'b11;
        end else if ((v.f3 % 4 == 1 && off % 2 != 0) || (v.f3 == 2 && off != 0)) begin
            e.err = 1'b1; e.code = 2'b01;
        end else if (v.gw >= TO) begin
            e.nreq = TO; e.done_cyc = TO + 1; e.err = 1'b1; e.code = 2'b10;
        end else begin
            e.nreq = v.gw + 1;
            if (v.wr) e.done_cyc = v.gw + 2;
            else begin
                c = v.gw + 1 + v.rv;
                if (c > TO) begin
                    e.done_cyc = TO + 1; e.err = 1'b1; e.code = 2'b10;
                end else begin
                    e.done_cyc = c + 1;
                    lane = v.rdata >> (8 * off);
                    case (v.f3)
                        0: begin lane = lane % 256;   e.ld = (lane >= 128)   ? lane - 256   : lane; end
                        4: e.ld = lane % 256;
                        1: begin lane = lane % 65536; e.ld = (lane >= 32768) ? lane - 65536 : lane; end
                        5: e.ld = lane % 65536;
                        default: e.ld = v.rdata;
                    endcase
                end
            end
        end
        return e;
    endfunction

    // Drive one op starting in an IDLE cycle, act as the memory, and record
    // what the DUT did up to one cycle after done.
    task automatic run_op(input vec_t v, output obs_t o);
        int nreq = 0;
        int gcyc = -1;
        o = '{done_cyc: -1, err: 1'b0, code: 2'b00, ld: 32'h0, addr: 32'h0,
              wd: 32'h0, ld_after: 32'h0, be: 4'h0, we: 1'b0, stable: 1'b1,
              busy_t: 1'b0, busy_mid: 1'b1, busy_done: 1'b0, done_after: 1'b0,
              nreq: 0};
        req_valid = 1'b1; mem_read = v.rd; mem_write = v.wr;
        funct3 = v.f3; addr = v.a; wdata = v.wd;
        #1;
        o.busy_t = busy;
        @(posedge clk); #1;
        // Scramble stage inputs: the DUT must work from what it latched.
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            if (done) begin
                o.done_cyc = cyc; o.err = err; o.code = err_code;
                o.ld = load_data; o.busy_done = busy;
                break;
            end
            if (!busy) o.busy_mid = 1'b0;
            if (dmem_req) begin
                if (nreq == 0) begin
                    o.addr = dmem_addr; o.be = dmem_be; o.we = dmem_we; o.wd = dmem_wdata;
                end else if (o.addr !== dmem_addr || o.be !== dmem_be ||
                             o.we !== dmem_we || o.wd !== dmem_wdata) begin
                    o.stable = 1'b0;
                end
                if (nreq == v.gw) begin dmem_gnt = 1'b1; gcyc = cyc; end
                nreq++;
            end
            if (v.rd && !v.wr && gcyc >= 0 && cyc == gcyc + v.rv) begin
                dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
            end
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        o.nreq = nreq;
        @(posedge clk); #1;
        o.done_after = done;
        o.ld_after = load_data;
    endtask

    task automatic judge(input string tag, input vec_t v, input exp_t e, input obs_t o);
        chk($sformatf("%s done_cycle", tag), o.done_cyc, e.done_cyc);
        chk($sformatf("%s err", tag), {31'h0, o.err}, {31'h0, e.err});
        chk($sformatf("%s err_code", tag), {30'h0, o.code}, {30'h0, e.code});
        chk($sformatf("%s load_data", tag), o.ld, e.ld);
        chk($sformatf("%s load_data_hold", tag), o.ld_after, e.ld);
        chk($sformatf("%s done_one_cycle", tag), {31'h0, o.done_after}, 32'h0);
        chk($sformatf("%s busy_accept", tag), {31'h0, o.busy_t}, 32'h1);
        chk($sformatf("%s busy_inflight", tag), {31'h0, o.busy_mid}, 32'h1);
        chk($sformatf("%s busy_at_done", tag), {31'h0, o.busy_done}, 32'h0);
        chk($sformatf("%s req_cycles", tag), o.nreq, e.nreq);
        if (e.nreq > 0) begin
            chk($sformatf("%s dmem_addr", tag), o.addr, e.addr);
            chk($sformatf("%s dmem_be", tag), {28'h0, o.be}, {28'h0, e.be});
            chk($sformatf("%s dmem_we", tag), {31'h0, o.we}, {31'h0, e.we});
            chk($sformatf("%s bus_stable", tag), {31'h0, o.stable}, 32'h1);
            if (v.wr) chk($sformatf("%s dmem_wdata", tag), o.wd, e.wd);
        end
    endtask

    function automatic tv_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input int gw, input int rv, input logic [31:0] rdata,
                               input int dc, input logic er, input logic [1:0] cd,
                               input logic [31:0] ld, input logic [3:0] be);
        tv_t t;
        t.v = '{rd: rd, wr: wr, f3: f3, a: a, wd: wd, rdata: rdata, gw: gw, rv: rv};
        t.done_cyc = dc; t.err = er; t.code = cd; t.ld = ld; t.be = be;
        return t;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk($sformatf("%s done", tag), {31'h0, done}, 32'h0);
        chk($sformatf("%s err", tag), {31'h0, err}, 32'h0);
        chk($sformatf("%s err_code", tag), {30'h0, err_code}, 32'h0);
        chk($sformatf("%s load_data", tag), load_data, 32'h0);
        chk($sformatf("%s dmem_req", tag), {31'h0, dmem_req}, 32'h0);
        chk($sformatf("%s dmem_we", tag), {31'h0, dmem_we}, 32'h0);
        chk($sformatf("%s dmem_addr", tag), dmem_addr, 32'h0);
        chk($sformatf("%s dmem_be", tag), {28'h0, dmem_be}, 32'h0);
        chk($sformatf("%s dmem_wdata", tag), dmem_wdata, 32'h0);
        chk($sformatf("%s busy", tag), {31'h0, busy}, 32'h0);
    endtask

    initial begin
        vec_t v;
        exp_t e;
        obs_t o;

        rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;

        //        rd wr f3    addr          wdata         gw   rv  rdata           done err code ld            be
        tv[0]  = mk(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0,   0,  32'h0,          2,  0, 2'd0, 32'h0,        4'hF);
        tv[1]  = mk(1, 0, 3'd0, 32'h203, 32'h0,       0,   1,  32'h80FF7F01,   3,  0, 2'd0, 32'hFFFFFF80, 4'h8);
        tv[2]  = mk(1, 0, 3'd4, 32'h203, 32'h0,       0,   1,  32'h80FF7F01,   3,  0, 2'd0, 32'h00000080, 4'h8);
        tv[3]  = mk(1, 0, 3'd1, 32'h202, 32'h0,       0,   0,  32'h80011234,   2,  0, 2'd0, 32'hFFFF8001, 4'hC);
        tv[4]  = mk(1, 0, 3'd5, 32'h202, 32'h0,       0,   0,  32'h80011234,   2,  0, 2'd0, 32'h00008001, 4'hC);
        tv[5]  = mk(0, 1, 3'd1, 32'h101, 32'h1234,    0,   0,  32'h0,          1,  1, 2'd1, 32'h0,        4'h0);
        tv[6]  = mk(1, 0, 3'd3, 32'h200, 32'h0,       0,   0,  32'h0,          1,  1, 2'd3, 32'h0,        4'h0);
        tv[7]  = mk(1, 1, 3'd2, 32'h200, 32'h0,       0,   0,  32'h0,          1,  1, 2'd3, 32'h0,        4'h0);
        tv[8]  = mk(1, 0, 3'd2, 32'h300, 32'h0,       255, 0,  32'h0,          65, 1, 2'd2, 32'h0,        4'hF);
        tv[9]  = mk(1, 0, 3'd1, 32'h203, 32'h0,       0,   0,  32'h0,          1,  1, 2'd1, 32'h0,        4'h0);
        tv[10] = mk(0, 1, 3'd2, 32'h102, 32'h0,       0,   0,  32'h0,          1,  1, 2'd1, 32'h0,        4'h0);
        tv[11] = mk(1, 0, 3'd0, 32'h001, 32'h0,       0,   63, 32'h00007F00,   65, 0, 2'd0, 32'h0000007F, 4'h2);
        tv[12] = mk(1, 0, 3'd0, 32'h001, 32'h0,       0,   64, 32'h00007F00,   65, 1, 2'd2, 32'h0,        4'h2);
        tv[13] = mk(0, 1, 3'd0, 32'h002, 32'h5A,      63,  0,  32'h0,          65, 0, 2'd0, 32'h0,        4'h4);
        tv[14] = mk(0, 1, 3'd0, 32'h002, 32'h5A,      64,  0,  32'h0,          65, 1, 2'd2, 32'h0,        4'h4);
        tv[15] = mk(0, 1, 3'd6, 32'h000, 32'h1,       0,   0,  32'h0,          1,  1, 2'd3, 32'h0,        4'h0);
        tv[16] = mk(1, 0, 3'd2, 32'h204, 32'h0,       3,   2,  32'h12345678,   7,  0, 2'd0, 32'h12345678, 4'hF);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: expected done/err/code/data/lanes come from the table;
        // address, write data and request count from the model.
        for (int i = 0; i < 17; i++) begin
            e = model(tv[i].v);
            e.done_cyc = tv[i].done_cyc; e.err = tv[i].err; e.code = tv[i].code;
            e.ld = tv[i].ld; e.be = tv[i].be;
            run_op(tv[i].v, o);
            judge($sformatf("tv%0d", i), tv[i].v, e, o);
        end

        // Reset while a load waits for rvalid, then a late rvalid arrives.
        req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'd2; addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0;
        chk("rstwait req_in_REQ", {31'h0, dmem_req}, 32'h1);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        chk("rstwait req_in_WAIT", {31'h0, dmem_req}, 32'h0);
        chk("rstwait busy_in_WAIT", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs("rstwait");
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rstwait late_rvalid done c%0d", k), {31'h0, done}, 32'h0);
            chk($sformatf("rstwait late_rvalid req c%0d", k), {31'h0, dmem_req}, 32'h0);
            @(posedge clk); #1;
        end
        v = '{rd: 1'b0, wr: 1'b1, f3: 3'd0, a: 32'h3, wd: 32'hAB, rdata: 32'h0, gw: 0, rv: 0};
        run_op(v, o);
        judge("sb_after_rst", v, model(v), o);
        chk("sb_after_rst be_const", {28'h0, o.be}, 32'h8);
        chk("sb_after_rst wdata_const", o.wd, 32'hABABABAB);

        // req_valid with neither read nor write is ignored.
        req_valid = 1'b1; funct3 = 3'd2; addr = 32'h80;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("noop busy c%0d", k), {31'h0, busy}, 32'h0);
            @(posedge clk); #1;
            chk($sformatf("noop req c%0d", k), {31'h0, dmem_req}, 32'h0);
            chk($sformatf("noop done c%0d", k), {31'h0, done}, 32'h0);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;

        // Randomized ops against the model.
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 9);
            v.rd = (r < 5);
            v.wr = (r == 0) || (r >= 5);
            if ($urandom_range(0, 3) == 0) v.f3 = 3'($urandom_range(0, 7));
            else begin
                r = $urandom_range(0, 4);
                v.f3 = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : (r == 2) ? 3'd2 : (r == 3) ? 3'd4 : 3'd5;
            end
            v.a = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                if (v.f3[1:0] == 2'b01) v.a[0] = 1'b0;
                if (v.f3 == 3'd2) v.a[1:0] = 2'b00;
            end
            v.wd = $urandom;
            v.rdata = $urandom;
            v.gw = ($urandom_range(0, 15) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 3);
            v.rv = ($urandom_range(0, 15) == 0) ? $urandom_range(55, 66) : $urandom_range(0, 3);
            run_op(v, o);
            judge($sformatf("rnd%0d", i), v, model(v), o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Load/store unit for the memory stage. It takes the ALU's 32-bit result as the effective address, plus store data and funct3. It runs one data-memory transaction over a req/gnt/rvalid handshake and returns aligned, sign- or zero-extended load data. While a transaction is in flight it holds `busy` high to stall the pipeline, and it reports misaligned, illegal-size and bus-timeout errors.

Parameters:
TIMEOUT, 64, cycles spent in REQ+WAIT before aborting with a bus-timeout error; must be >= 2.
CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  memory op present in the stage.
mem_read  input  1  load op.
mem_write  input  1  store op.
funct3  input  3  size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
addr  input  32  effective address (ALU result).
wdata  input  32  store data (rs2).
busy  output  1  stall request to the pipeline.
done  output  1  one-cycle completion pulse.
load_data  output  32  extended load result; valid while done=1.
err  output  1  valid with done; transaction failed.
err_code  output  2  01 misaligned, 10 bus timeout, 11 illegal funct3 or both read and write set.
dmem_req  output  1  bus request.
dmem_we  output  1  1 = write.
dmem_addr  output  32  word-aligned address: {addr[31:2], 2'b00}.
dmem_be  output  4  byte enables.
dmem_wdata  output  32  lane-replicated store data.
dmem_gnt  input  1  request accepted.
dmem_rvalid  input  1  read data valid.
dmem_rdata  input  32  read data word.

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset: state=IDLE; timeout counter=0; done=0; err=0; err_code=00; load_data=0; dmem_req=0; dmem_we=0; dmem_addr=0; dmem_be=0; dmem_wdata=0.
- Reset mid-operation: IDLE on the next edge and dmem_req low. Any late gnt/rvalid is ignored in IDLE.
- States are IDLE, REQ, WAIT, DONE.
- IDLE:
  - If req_valid and exactly one of mem_read/mem_write is set, latch the op, size, addr[1:0] and bus fields, then go to REQ.
  - If req_valid with neither set, ignore it.
  - Errors detected at accept go to DONE directly with err=1 and no bus request:
    - illegal funct3 or both read and write set: code 11.
    - H/HU with addr[0]=1, or W with addr[1:0]!=00: code 01.
- REQ:
  - dmem_req=1 with registered fields held stable until gnt.
  - Store with gnt: go to DONE (no rvalid expected).
  - Load with gnt and no rvalid: go to WAIT.
  - Load with gnt and rvalid in the same cycle: capture data and go to DONE.
- WAIT: dmem_req=0. On rvalid, capture the extended data and go to DONE.
- Timeout:
  - The counter clears on accept and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT-1 with no completing gnt/rvalid: go to DONE, err=1, code 10, drop dmem_req.
  - A completion in the same cycle wins over the timeout.
- DONE: done=1 for exactly one cycle, then IDLE. A new request is accepted earliest in the following IDLE cycle.
- busy (combinational) = (state is REQ or WAIT) or (state is IDLE and req_valid and (mem_read or mem_write)). It is 0 in DONE so the pipeline advances with the result.
- Byte enables:
  - B/BU: 0001<<addr[1:0].
  - H/HU: 0011<<addr[1:0].
  - W: 1111.
  - Reads drive the same BE.
- Store data:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
- Load extract:
  - sh = dmem_rdata >> (8*addr[1:0]).
  - B: sign-extend sh[7:0].
  - BU: zero-extend sh[7:0].
  - H: sign-extend sh[15:0].
  - HU: zero-extend sh[15:0].
  - W: dmem_rdata.
- load_data: holds its last value outside done; 0 after a store or an error.
- Latency with gnt in the first REQ cycle:
  - store: accept T, REQ T+1, done T+2.
  - load with rvalid one cycle after gnt: done T+3.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt immediate -> dmem_addr=0x100, be=1111, we=1, wdata=0xDEADBEEF; done at T+2 with err=0; busy high T..T+1.
- LB addr=0x203, rdata=0x80FF7F01, rvalid one cycle after gnt -> be=1000, load_data=0xFFFFFF80; with LBU -> 0x00000080.
- LH addr=0x202, rdata=0x8001_1234, gnt and rvalid same cycle -> load_data=0xFFFF8001, done at T+2; LHU -> 0x00008001.
- SH addr=0x101 -> no dmem_req, done at T+1 with err=1, code 01; funct3=011 -> code 11; mem_read and mem_write both set -> code 11.
- LW with gnt never asserted, TIMEOUT=64 -> dmem_req high 64 cycles then low, done with err=1, code 10, busy low after.
- rst asserted in WAIT, then rvalid arrives -> state IDLE, no done pulse, all outputs at reset values; next SB addr=0x3, wdata=0xAB -> be=1000, wdata=0xABABABAB.
